wb_regfile: RTL and testbench
=============================

# wb_regfile

Parametrised write-back stage and general-register file for the pipelined CPU. It retires results from the WB pipeline slot into an N-entry, W-bit register array and serves any number of combinational read ports, bypassing same-cycle write-back data to them. A per-register pending-write scoreboard lets decode stall on RAW hazards instead of relying on fixed pipeline spacing.

## Interface
Parameters:
- DATA_W, 16, register and result width
- NREG, 8, number of general registers; power of two, 2..8
- NRD, 2, number of read ports
- CNT_W, 2, width of each pending-write counter; maximum in-flight writes per register is 2^CNT_W-1
- DST_LSB, 8, LSB of the destination field in wb_ir; the field is AW = log2(NREG) bits wide

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low
- state  in  1  CPU run state; `exec` enables issue and write-back
- wb_ir  in  16  instruction in the WB slot
- reg_C1  in  DATA_W  result to retire
- iss_valid  in  1  decode issues an instruction that writes iss_rd
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue accepted this cycle
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*DATA_W  read data, with bypass
- rd_busy  out  NRD  source still has an outstanding write
- gr_flat  out  NREG*DATA_W  all registers, gr k at [k*DATA_W +: DATA_W]
- wb_done  out  1  registered pulse: a write retired in the previous cycle
- sb_err  out  1  sticky scoreboard underflow flag

## Operation
- wb_we = (state == `exec`) && is_wb_op(wb_ir[15:11]). The write-back opcode set is LOAD, MOVI, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SHL, SHR, CAL, CAR. All other opcodes retire nothing.
- wb_dst = wb_ir[DST_LSB +: AW]. On wb_we, gr[wb_dst] <= reg_C1.
- Read port i, combinational: if wb_we && rd_addr_i == wb_dst, rd_data_i = reg_C1; otherwise rd_data_i = gr[rd_addr_i].
- iss_ready = (state == `exec`) && cnt[iss_rd] != 2^CNT_W-1. An issue occurs when iss_valid && iss_ready.
- Counter update for each register k, with inc = issue to k and dec = wb_we to k:
  - inc only: +1
  - dec only: -1
  - both: unchanged
  - dec only while cnt is 0: cnt stays 0 and sb_err <= 1
- rd_busy_i = cnt[rd_addr_i] != 0, except when the only outstanding write retires this cycle (cnt == 1 && wb_we && wb_dst == rd_addr_i && no same-register issue). In that case rd_busy_i = 0, and bypassed data is valid.
- wb_done <= wb_we.
- When state != `exec`: no issue and no write. Counters, registers and sb_err hold.

## Timing
- Reset (reset == 0 at a clock edge) clears all of the following:
  - all gr: 0
  - all cnt: 0
  - wb_done: 0
  - sb_err: 0
- While in reset, gr_flat = 0 and rd_data reflects the zeroed array. rd_busy = 0.
- iss_ready is 0 while reset is low, and during reset no issue is accepted.
- Reset mid-operation discards all pending counts. Decode must flush in-flight instructions alongside it.
- Write latency: the gr_flat / array value updates at the edge ending the wb_we cycle. Read ports see the new value the same cycle via bypass.
- Issue and write-back to the same register in the same cycle are legal; the net count change is 0.
- sb_err clears only on reset.
- No combinational path from iss_valid to iss_ready.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants and state encoding (`exec`)
  - function is_wb_op(opcode)
  - the DEST_LSB default
- Sub-module wb_scoreboard: the NREG counters, iss_ready, rd_busy and sb_err.
- wb_regfile instantiates wb_scoreboard and contains the array, the bypass muxes and wb_done.

## Test plan
- Reset then write-back: state=exec, wb_ir={ADD,gr3}, reg_C1=16'h1234 -> next cycle gr3=16'h1234 and wb_done=1; all other gr = 0.
- Bypass: rd_addr0=gr3 in the same cycle as the write of 16'hBEEF to gr3 -> rd_data0=16'hBEEF that cycle, rd_busy0=0 when cnt was 1.
- Non-writing and idle: wb_ir={JUMP,...} or state!=exec with ADD -> no gr change and wb_done=0.
- Scoreboard saturation (CNT_W=2): three issues to gr5 -> iss_ready=0 for gr5 and a fourth issue is refused. Three write-backs to gr5 -> cnt=0 and rd_busy=0.
- Simultaneous issue and write-back to gr2 with cnt=1 -> cnt stays 1 and rd_busy stays 1. A write-back with cnt=0 -> sb_err=1 until reset.
- Parametrisation: DATA_W=32, NREG=4, NRD=3 -> all three ports read and bypass independently. A synchronous reset asserted mid-stream zeroes every register and counter at the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, run-state encoding and the write-back
// opcode classifier used by the register-file stage.
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_LOAD  = 5'd1,
        OP_STORE = 5'd2,
        OP_MOVI  = 5'd3,
        OP_ADD   = 5'd4,
        OP_ADDI  = 5'd5,
        OP_ADDC  = 5'd6,
        OP_SUB   = 5'd7,
        OP_SUBI  = 5'd8,
        OP_SUBC  = 5'd9,
        OP_CMP   = 5'd10,
        OP_AND   = 5'd11,
        OP_OR    = 5'd12,
        OP_XOR   = 5'd13,
        OP_SHL   = 5'd14,
        OP_SHR   = 5'd15,
        OP_JUMP  = 5'd16,
        OP_JMPR  = 5'd17,
        OP_BZ    = 5'd18,
        OP_BNZ   = 5'd19,
        OP_BN    = 5'd20,
        OP_BNN   = 5'd21,
        OP_BC    = 5'd22,
        OP_BNC   = 5'd23,
        OP_CAL   = 5'd24,
        OP_CAR   = 5'd25,
        OP_HALT  = 5'd31
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } cpu_state_e;

    localparam int DEST_LSB = 8;

    function automatic logic is_wb_op(input logic [4:0] op);
        case (op)
            OP_LOAD, OP_MOVI, OP_ADD, OP_ADDI, OP_ADDC,
            OP_SUB, OP_SUBI, OP_SUBC, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR, OP_CAL, OP_CAR: is_wb_op = 1'b1;
            default:                                is_wb_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Per-register pending-write counters: gate issue on counter headroom and
// report which read sources still wait on an outstanding result.
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int NRD   = 2,
    parameter int CNT_W = 2,
    parameter int AW    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              exec_en,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_dst,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic              iss_ready,
    output logic [NRD-1:0]    rd_busy,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;
    logic [NREG-1:0]  underflow;
    logic             issue;
    logic             sb_err_reg;

    // iss_valid never feeds iss_ready, so decode can build valid from ready.
    assign iss_ready = reset && exec_en && (cnt_reg[iss_rd] != CNT_MAX);
    assign issue     = iss_valid && iss_ready;
    assign sb_err    = sb_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            assign inc[gi]       = issue && (iss_rd == AW'(gi));
            assign dec[gi]       = wb_we && (wb_dst == AW'(gi));
            assign underflow[gi] = dec[gi] && !inc[gi] && (cnt_reg[gi] == '0);

            always_ff @(posedge clock) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi] && !dec[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end else if (dec[gi] && !inc[gi] && (cnt_reg[gi] != '0)) begin
                    cnt_reg[gi] <= cnt_reg[gi] - CNT_W'(1);
                end
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_busy
            logic [AW-1:0] a;
            assign a = rd_addr[gi*AW +: AW];
            // A last outstanding write retiring now is covered by the bypass.
            assign rd_busy[gi] = reset && (cnt_reg[a] != '0) &&
                                 !((cnt_reg[a] == CNT_W'(1)) && dec[a] && !inc[a]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            sb_err_reg <= 1'b0;
        end else if (|underflow) begin
            sb_err_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and general-register file with same-cycle bypass to all
// read ports; hazard tracking lives in wb_scoreboard.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  NREG    = 8,
    parameter int  NRD     = 2,
    parameter int  CNT_W   = 2,
    parameter int  DST_LSB = DEST_LSB,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   state,
    input  logic [15:0]            wb_ir,
    input  logic [DATA_W-1:0]      reg_C1,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    output logic                   iss_ready,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_busy,
    output logic [NREG*DATA_W-1:0] gr_flat,
    output logic                   wb_done,
    output logic                   sb_err
);

    logic              exec_en;
    logic              wb_we;
    logic [AW-1:0]     wb_dst;
    logic [DATA_W-1:0] gr_reg [NREG];
    logic              wb_done_reg;
    logic              unused_ir;

    assign exec_en   = (state == ST_EXEC);
    assign wb_we     = reset && exec_en && is_wb_op(wb_ir[15:11]);
    assign wb_dst    = wb_ir[DST_LSB +: AW];
    assign wb_done   = wb_done_reg;
    assign unused_ir = ^wb_ir;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++) begin
                gr_reg[k] <= '0;
            end
            wb_done_reg <= 1'b0;
        end else begin
            wb_done_reg <= wb_we;
            if (wb_we) begin
                gr_reg[wb_dst] <= reg_C1;
            end
        end
    end

    // Outputs read as zero while reset is held, before the clearing edge.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_flat
            assign gr_flat[gi*DATA_W +: DATA_W] = reset ? gr_reg[gi] : '0;
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] a;
            assign a = rd_addr[gi*AW +: AW];
            assign rd_data[gi*DATA_W +: DATA_W] =
                !reset                   ? '0     :
                (wb_we && (a == wb_dst)) ? reg_C1 : gr_reg[a];
        end
    endgenerate

    wb_scoreboard #(
        .NREG  (NREG),
        .NRD   (NRD),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_sb (
        .clock     (clock),
        .reset     (reset),
        .exec_en   (exec_en),
        .wb_we     (wb_we),
        .wb_dst    (wb_dst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rd_addr   (rd_addr),
        .iss_ready (iss_ready),
        .rd_busy   (rd_busy),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios on the default build and a
// randomized model-checked stream on a 32-bit / 4-register / 3-port build.
module tb_wb_regfile;
    import cpu_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // default instance
    logic         reset0, state0, iv0;
    logic [15:0]  wb_ir0, c1_0;
    logic [2:0]   ir0;
    logic [5:0]   ra0;
    logic         ready0, done0, err0;
    logic [31:0]  rd0;
    logic [1:0]   busy0;
    logic [127:0] gf0;

    // wide instance
    logic         reset1, state1, iv1;
    logic [15:0]  wb_ir1;
    logic [31:0]  c1_1;
    logic [1:0]   ir1;
    logic [5:0]   ra1;
    logic         ready1, done1, err1;
    logic [95:0]  rd1;
    logic [2:0]   busy1;
    logic [127:0] gf1;

    wb_regfile u0 (
        .clock(clock), .reset(reset0), .state(state0), .wb_ir(wb_ir0),
        .reg_C1(c1_0), .iss_valid(iv0), .iss_rd(ir0), .iss_ready(ready0),
        .rd_addr(ra0), .rd_data(rd0), .rd_busy(busy0), .gr_flat(gf0),
        .wb_done(done0), .sb_err(err0)
    );

    wb_regfile #(.DATA_W(32), .NREG(4), .NRD(3)) u1 (
        .clock(clock), .reset(reset1), .state(state1), .wb_ir(wb_ir1),
        .reg_C1(c1_1), .iss_valid(iv1), .iss_rd(ir1), .iss_ready(ready1),
        .rd_addr(ra1), .rd_data(rd1), .rd_busy(busy1), .gr_flat(gf1),
        .wb_done(done1), .sb_err(err1)
    );

    function automatic logic [15:0] mkir(input logic [4:0] op, input logic [2:0] dst);
        return {op, dst, 8'h00};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset0 = 1'b0; state0 = 1'b1; iv0 = 1'b1; ir0 = 3'd5;
        wb_ir0 = mkir(OP_ADD, 3'd1); c1_0 = 16'hFFFF; ra0 = {3'd1, 3'd5};
        #1;
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready0); end
        tick;
        total++; if (gf0 !== 128'h0) begin bad++; $display("FAIL reset_gr got=%h want=0", gf0); end
        total++; if (done0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL reset_flags done=%b err=%b want=0,0", done0, err0); end
        total++; if (busy0 !== 2'b00 || rd0 !== 32'h0) begin bad++; $display("FAIL reset_rd busy=%b data=%h want=0,0", busy0, rd0); end
        reset0 = 1'b1; iv0 = 1'b0; wb_ir0 = mkir(OP_NOP, 3'd0);
        #1;
        total++; if (busy0 !== 2'b00 || rd0 !== 32'h0) begin bad++; $display("FAIL reset_noissue busy=%b data=%h want=0,0", busy0, rd0); end
        total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", ready0); end
    endtask

    task automatic test_writeback;
        iv0 = 1'b1; ir0 = 3'd3; #1; tick;
        iv0 = 1'b0; wb_ir0 = mkir(OP_ADD, 3'd3); c1_0 = 16'h1234; ra0 = {3'd0, 3'd3};
        #1;
        total++; if (busy0 !== 2'b00) begin bad++; $display("FAIL wb_busy got=%b want=00", busy0); end
        total++; if (rd0 !== 32'h0000_1234) begin bad++; $display("FAIL wb_bypass got=%h want=00001234", rd0); end
        tick;
        wb_ir0 = mkir(OP_NOP, 3'd0); #1;
        total++; if (gf0 !== (128'h1234 << 48)) begin bad++; $display("FAIL wb_gr got=%h want=gr3 1234 only", gf0); end
        total++; if (done0 !== 1'b1 || err0 !== 1'b0) begin bad++; $display("FAIL wb_done done=%b err=%b want=1,0", done0, err0); end
        tick;
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL wb_done_clear got=%b want=0", done0); end
    endtask

    task automatic test_bypass;
        iv0 = 1'b1; ir0 = 3'd3; #1; tick;
        iv0 = 1'b0; ra0 = {3'd3, 3'd3}; #1;
        total++; if (busy0 !== 2'b11 || rd0 !== 32'h1234_1234) begin bad++; $display("FAIL byp_pending busy=%b data=%h want=11,12341234", busy0, rd0); end
        wb_ir0 = mkir(OP_ADD, 3'd3); c1_0 = 16'hBEEF; #1;
        total++; if (busy0 !== 2'b00 || rd0 !== 32'hBEEF_BEEF) begin bad++; $display("FAIL byp_same busy=%b data=%h want=00,BEEFBEEF", busy0, rd0); end
        tick;
        wb_ir0 = mkir(OP_NOP, 3'd0); #1;
        total++; if (gf0[63:48] !== 16'hBEEF) begin bad++; $display("FAIL byp_gr3 got=%h want=BEEF", gf0[63:48]); end
    endtask

    task automatic test_nonwrite;
        wb_ir0 = mkir(OP_JUMP, 3'd3); c1_0 = 16'hDEAD; #1; tick;
        total++; if (gf0[63:48] !== 16'hBEEF || done0 !== 1'b0) begin bad++; $display("FAIL nw_jump gr3=%h done=%b want=BEEF,0", gf0[63:48], done0); end
        state0 = 1'b0; wb_ir0 = mkir(OP_ADD, 3'd3); iv0 = 1'b1; ir0 = 3'd4; #1;
        total++; if (ready0 !== 1'b0 || rd0[15:0] !== 16'hBEEF) begin bad++; $display("FAIL nw_idle ready=%b rd=%h want=0,BEEF", ready0, rd0[15:0]); end
        tick;
        total++; if (gf0[63:48] !== 16'hBEEF || done0 !== 1'b0) begin bad++; $display("FAIL nw_idle_gr gr3=%h done=%b want=BEEF,0", gf0[63:48], done0); end
        state0 = 1'b1; iv0 = 1'b0; wb_ir0 = mkir(OP_NOP, 3'd0); ra0 = {3'd4, 3'd4}; #1;
        total++; if (busy0 !== 2'b00 || err0 !== 1'b0) begin bad++; $display("FAIL nw_idle_issue busy=%b err=%b want=00,0", busy0, err0); end
    endtask

    task automatic test_saturation;
        iv0 = 1'b1; ir0 = 3'd5; ra0 = {3'd5, 3'd5}; wb_ir0 = mkir(OP_NOP, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL sat_ready%0d got=%b want=1", i, ready0); end
            tick;
        end
        #1;
        total++; if (ready0 !== 1'b0 || busy0 !== 2'b11) begin bad++; $display("FAIL sat_full ready=%b busy=%b want=0,11", ready0, busy0); end
        tick;
        iv0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_ir0 = mkir(OP_SUB, 3'd5); c1_0 = 16'(i + 1); #1;
            total++; if (busy0[0] !== (i < 2)) begin bad++; $display("FAIL sat_drain%0d busy=%b want=%b", i, busy0[0], (i < 2)); end
            tick;
        end
        wb_ir0 = mkir(OP_NOP, 3'd0); #1;
        total++; if (busy0 !== 2'b00 || ready0 !== 1'b1) begin bad++; $display("FAIL sat_empty busy=%b ready=%b want=00,1", busy0, ready0); end
        total++; if (gf0[95:80] !== 16'h0003 || err0 !== 1'b0) begin bad++; $display("FAIL sat_gr5 gr5=%h err=%b want=0003,0", gf0[95:80], err0); end
    endtask

    task automatic test_simul;
        iv0 = 1'b1; ir0 = 3'd2; ra0 = {3'd2, 3'd0}; #1; tick;
        wb_ir0 = mkir(OP_XOR, 3'd2); c1_0 = 16'h7777; #1;
        total++; if (busy0[1] !== 1'b1 || rd0[31:16] !== 16'h7777) begin bad++; $display("FAIL sim_same busy=%b rd=%h want=1,7777", busy0[1], rd0[31:16]); end
        tick;
        iv0 = 1'b0; wb_ir0 = mkir(OP_NOP, 3'd0); #1;
        total++; if (busy0[1] !== 1'b1 || gf0[47:32] !== 16'h7777) begin bad++; $display("FAIL sim_hold busy=%b gr2=%h want=1,7777", busy0[1], gf0[47:32]); end
        wb_ir0 = mkir(OP_MOVI, 3'd2); c1_0 = 16'h0042; #1; tick;
        wb_ir0 = mkir(OP_NOP, 3'd0); #1;
        total++; if (busy0[1] !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL sim_done busy=%b err=%b want=0,0", busy0[1], err0); end
    endtask

    task automatic test_underflow;
        wb_ir0 = mkir(OP_LOAD, 3'd6); c1_0 = 16'h5A5A; #1; tick;
        wb_ir0 = mkir(OP_NOP, 3'd0); #1;
        total++; if (err0 !== 1'b1 || gf0[111:96] !== 16'h5A5A) begin bad++; $display("FAIL uf_set err=%b gr6=%h want=1,5A5A", err0, gf0[111:96]); end
        tick; tick;
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", err0); end
        reset0 = 1'b0; #1; tick;
        reset0 = 1'b1; #1;
        total++; if (err0 !== 1'b0 || gf0 !== 128'h0 || done0 !== 1'b0) begin bad++; $display("FAIL uf_reset err=%b gr=%h done=%b want=0,0,0", err0, gf0, done0); end
    endtask

    task automatic test_param;
        logic [31:0] m_gr [4];
        int          m_cnt [4];
        bit          m_err, m_done, rst, we, iss, xbusy;
        logic [4:0]  op;
        logic [2:0]  dst;
        logic [1:0]  d, a;
        logic [31:0] xdata;
        logic [127:0] xflat;
        int          delta;
        reset1 = 1'b0; state1 = 1'b1; iv1 = 1'b0; wb_ir1 = 16'h0; c1_1 = 32'h0; ir1 = 2'd0; ra1 = 6'd0;
        #1; tick;
        for (int k = 0; k < 4; k++) begin m_gr[k] = '0; m_cnt[k] = 0; end
        m_err = 1'b0; m_done = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset1 = (cyc == 200) ? 1'b0 : ($urandom_range(0, 60) != 0);
            state1 = ($urandom_range(0, 7) != 0);
            op     = 5'($urandom_range(0, 31));
            dst    = 3'($urandom_range(0, 7));
            wb_ir1 = {op, dst, 8'($urandom)};
            c1_1   = $urandom;
            iv1    = ($urandom_range(0, 3) != 0);
            ir1    = 2'($urandom_range(0, 3));
            ra1    = 6'($urandom);
            #1;
            rst = reset1;
            d   = dst[1:0];
            we  = rst && state1 && (op inside {OP_LOAD, OP_MOVI, OP_ADD, OP_ADDI, OP_ADDC,
                                               OP_SUB, OP_SUBI, OP_SUBC, OP_AND, OP_OR,
                                               OP_XOR, OP_SHL, OP_SHR, OP_CAL, OP_CAR});
            total++; if (ready1 !== (rst && state1 && m_cnt[ir1] != 3)) begin bad++; $display("FAIL p_ready cyc=%0d got=%b want=%b", cyc, ready1, (rst && state1 && m_cnt[ir1] != 3)); end
            iss = iv1 && rst && state1 && (m_cnt[ir1] != 3);
            for (int p = 0; p < 3; p++) begin
                a     = ra1[p*2 +: 2];
                xdata = !rst ? 32'h0 : (we && a == d) ? c1_1 : m_gr[a];
                xbusy = rst && (m_cnt[a] != 0) && !(m_cnt[a] == 1 && we && d == a && !(iss && ir1 == a));
                total++; if (rd1[p*32 +: 32] !== xdata) begin bad++; $display("FAIL p_rd%0d cyc=%0d got=%h want=%h", p, cyc, rd1[p*32 +: 32], xdata); end
                total++; if (busy1[p] !== xbusy) begin bad++; $display("FAIL p_busy%0d cyc=%0d got=%b want=%b", p, cyc, busy1[p], xbusy); end
            end
            xflat = '0;
            if (rst) for (int k = 0; k < 4; k++) xflat[k*32 +: 32] = m_gr[k];
            total++; if (gf1 !== xflat) begin bad++; $display("FAIL p_gr cyc=%0d got=%h want=%h", cyc, gf1, xflat); end
            total++; if (done1 !== m_done || err1 !== m_err) begin bad++; $display("FAIL p_flags cyc=%0d done=%b err=%b want=%b,%b", cyc, done1, err1, m_done, m_err); end
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin m_gr[k] = '0; m_cnt[k] = 0; end
                m_err = 1'b0; m_done = 1'b0;
            end else begin
                if (we) m_gr[d] = c1_1;
                for (int k = 0; k < 4; k++) begin
                    delta = ((iss && ir1 == k) ? 1 : 0) - ((we && d == k) ? 1 : 0);
                    if (delta < 0 && m_cnt[k] == 0) m_err = 1'b1;
                    else m_cnt[k] = m_cnt[k] + delta;
                end
                m_done = we;
            end
            tick;
        end
    endtask

    initial begin
        reset1 = 1'b0; state1 = 1'b0; iv1 = 1'b0; wb_ir1 = 16'h0; c1_1 = 32'h0; ir1 = 2'd0; ra1 = 6'd0;
        test_reset;
        test_writeback;
        test_bypass;
        test_nonwrite;
        test_saturation;
        test_simul;
        test_underflow;
        test_param;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
